sequence_player: RTL

- Presents a stored memory-game bit sequence to the player before the entry phase: one bit at a time, MSB first, each held on an indicator for a fixed dwell followed by a blank gap.
- Sits upstream of the level entry checker. Both blocks consume the same 25-bit sequence, and bit 24 is shown first because it is the first bit checked.
- Signals completion so top-level control can hand over to the entry phase.

---
 rtl/memgame_pkg.sv | 20 ++
 rtl/sequence_player_dwell_timer.sv | 36 +++
 rtl/sequence_player.sv | 135 +++++++++++++
 3 files changed

// File: rtl/memgame_pkg.sv
// Shared types and helpers for the memory-game sequence blocks.
// Both the player and the entry checker consume a SEQ_W-bit sequence, MSB first.
package memgame_pkg;

    localparam int SEQ_W = 25;
    localparam int LEN_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sequence_player_dwell_timer.sv
// Loadable down-counter used for both the show dwell and the blank gap.
// Counts only on tick and parks at zero; load has priority over counting.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays a latched bit sequence MSB first on an indicator: ON_TICKS shown, GAP_TICKS blank.
// Pulses done for one cycle after the last gap so control can hand over to entry.
module sequence_player #(
    parameter int SEQ_W     = 25,
    parameter int ON_TICKS  = 3,
    parameter int GAP_TICKS = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       len,
    input  logic [SEQ_W-1:0] seq,
    output logic             led_bit,
    output logic             led_valid,
    output logic [4:0]       idx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_state
);

    import memgame_pkg::*;

    localparam logic [CNT_W-1:0] ON_VAL  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_VAL = CNT_W'(GAP_TICKS - 1);
    localparam logic [4:0]       MAX_LEN = 5'(SEQ_W);

    state_e           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [4:0]       len_q, len_d;
    logic [4:0]       idx_q, idx_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tick;
    logic             tmr_zero;
    logic [4:0]       len_clamped;
    logic [4:0]       bit_pos;

    assign len_clamped = clamp_len(len, MAX_LEN);

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    seq_d = seq;
                    len_d = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SHOW;
                        idx_d    = '0;
                        tmr_load = 1'b1;
                        tmr_val  = ON_VAL;
                    end
                end
            end
            ST_SHOW: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && tmr_zero) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_VAL;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && tmr_zero) begin
                    if (idx_q == len_q - 5'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SHOW;
                        idx_d    = idx_q + 5'd1;
                        tmr_load = 1'b1;
                        tmr_val  = ON_VAL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Timer only advances while actually dwelling, so idle ticks never disturb it.
    assign tmr_tick = tick && !abort && ((state_q == ST_SHOW) || (state_q == ST_GAP));

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tick    (tmr_tick),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    assign bit_pos   = 5'(SEQ_W - 1) - idx_q;
    assign led_valid = (state_q == ST_SHOW);
    assign led_bit   = led_valid & seq_q[bit_pos];
    assign busy      = (state_q == ST_SHOW) || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);
    assign idx       = idx_q;
    assign o_state   = state_q;

endmodule
